// File: rtl/psk_symbol_mapper_if.sv
// Byte-in / symbol-out stream bundle for the PSK symbol mapper.
interface psk_symbol_mapper_if #(
    parameter int WIDTH = 16
);
    logic [7:0]              in_tdata;
    logic                    in_tvalid;
    logic                    in_tready;
    logic signed [WIDTH-1:0] out_I_tdata;
    logic signed [WIDTH-1:0] out_Q_tdata;
    logic                    out_tvalid;
    logic                    out_is_bpsk;

    modport slave (
        input  in_tdata, in_tvalid,
        output in_tready,
        output out_I_tdata, out_Q_tdata, out_tvalid, out_is_bpsk
    );

    modport master (
        output in_tdata, in_tvalid,
        input  in_tready,
        input  out_I_tdata, out_Q_tdata, out_tvalid, out_is_bpsk
    );
endinterface

// File: rtl/psk_symbol_mapper.sv
// BPSK/QPSK symbol mapper: byte stream -> signed I/Q points at a fixed symbol rate.
// Optional differential encoding when PSK_DIFF_ENC_EN is defined.
module psk_symbol_mapper #(
    parameter int WIDTH        = 16,
    parameter int AMP          = 8192,
    parameter int CLKS_PER_SYM = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                is_bpsk,
    psk_symbol_mapper_if.slave  bus,
    output logic                underrun
);
    localparam int CW = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SYM - 1);
    localparam logic signed [WIDTH-1:0] POS = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] NEG = -POS;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    rdy_q;
    logic [7:0]              hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [7:0]              shift_q, shift_d;
    logic [3:0]              bits_q, bits_d;
    logic                    mode_q, mode_d;
    logic signed [WIDTH-1:0] i_q, i_d, q_q, q_d;
    logic                    tv_q, tv_d;
    logic                    ob_q, ob_d;
    logic                    ur_q, ur_d;
`ifdef PSK_DIFF_ENC_EN
    logic [1:0]              phase_q, phase_d;
    logic [1:0]              step, p_new;
`endif

    logic       tick, accept, have, load, sm;
    logic       b1, b0, ni, nq;
    logic [7:0] src;

    assign bus.in_tready   = rdy_q & ~hold_full_q;
    assign bus.out_I_tdata = i_q;
    assign bus.out_Q_tdata = q_q;
    assign bus.out_tvalid  = tv_q;
    assign bus.out_is_bpsk = ob_q;
    assign underrun        = ur_q;

    always_comb begin
        tick   = enable & (cnt_q == LAST);
        accept = bus.in_tvalid & bus.in_tready;
        cnt_d  = cnt_q;
        if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

        have = 1'b0;
        load = 1'b0;
        src  = shift_q;
        sm   = mode_q;
        if (bits_q != 4'd0) begin
            have = 1'b1;
        end else if (hold_full_q) begin
            have = 1'b1;
            load = 1'b1;
            src  = hold_q;
            sm   = is_bpsk;
        end
        b1 = src[7];
        b0 = src[6];

`ifdef PSK_DIFF_ENC_EN
        step    = sm ? {b1, 1'b0} : {b1, b1 ^ b0};
        p_new   = phase_q + step;
        ni      = p_new[1] ^ p_new[0];
        nq      = p_new[1];
        phase_d = phase_q;
`else
        ni = b1;
        nq = sm ? b1 : b0;
`endif

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        // a same-cycle accept refills the hold slot the load just vacated
        if (tick & load) hold_full_d = accept;
        else if (accept) hold_full_d = 1'b1;
        if (accept) hold_d = bus.in_tdata;

        shift_d = shift_q;
        bits_d  = bits_q;
        mode_d  = mode_q;
        i_d     = i_q;
        q_d     = q_q;
        ob_d    = ob_q;
        ur_d    = ur_q;
        tv_d    = tick;
        if (tick) begin
            if (have) begin
                shift_d = sm ? {src[6:0], 1'b0} : {src[5:0], 2'b00};
                bits_d  = (load ? 4'd8 : bits_q) - (sm ? 4'd1 : 4'd2);
                mode_d  = sm;
                ob_d    = sm;
                i_d     = ni ? NEG : POS;
                q_d     = nq ? NEG : POS;
`ifdef PSK_DIFF_ENC_EN
                phase_d = p_new;
`endif
            end else begin
                i_d  = '0;
                q_d  = '0;
                ur_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bits_q      <= '0;
            mode_q      <= 1'b1;
            i_q         <= '0;
            q_q         <= '0;
            tv_q        <= 1'b0;
            ob_q        <= 1'b1;
            ur_q        <= 1'b0;
`ifdef PSK_DIFF_ENC_EN
            phase_q     <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            rdy_q       <= 1'b1;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bits_q      <= bits_d;
            mode_q      <= mode_d;
            i_q         <= i_d;
            q_q         <= q_d;
            tv_q        <= tv_d;
            ob_q        <= ob_d;
            ur_q        <= ur_d;
`ifdef PSK_DIFF_ENC_EN
            phase_q     <= phase_d;
`endif
        end
    end
endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Directed bench for psk_symbol_mapper: vector table plus multi-cycle sequences.
module tb_psk_symbol_mapper;
    localparam int WIDTH = 16;
    localparam int AMP   = 8192;
    localparam int CPS   = 4;
    localparam logic signed [WIDTH-1:0] PA = 16'sd8192;
    localparam logic signed [WIDTH-1:0] NA = -16'sd8192;

    logic clk = 1'b0;
    logic rst_n, enable, is_bpsk, underrun;
    int   checks = 0;
    int   failures = 0;

    psk_symbol_mapper_if #(.WIDTH(WIDTH)) bus ();

    psk_symbol_mapper #(
        .WIDTH(WIDTH), .AMP(AMP), .CLKS_PER_SYM(CPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .is_bpsk(is_bpsk),
        .bus(bus), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bpsk;
        logic [7:0]  data;
        int          nsym;
        logic [15:0] signs;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic next_pulse(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.out_tvalid && c < 40);
    endtask

    task automatic check_sym(input string nm, input bit ni, input bit nq,
                             input bit bp, input bit chk_gap);
        int c;
        next_pulse(c);
        chk({nm, " found"}, 32'(c < 40), 32'd1);
        if (c < 40) begin
            chk({nm, " I"}, bus.out_I_tdata, ni ? NA : PA);
            chk({nm, " Q"}, bus.out_Q_tdata, nq ? NA : PA);
            chk({nm, " mode"}, 32'(bus.out_is_bpsk), 32'(bp));
            if (chk_gap) chk({nm, " gap"}, c, CPS);
        end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        bus.in_tvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        bus.in_tdata  = d;
        bus.in_tvalid = 1'b1;
        n = 0;
        while (!bus.in_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send ready", 32'(bus.in_tready), 32'd1);
        @(negedge clk);
        bus.in_tvalid = 1'b0;
    endtask

    task automatic feed_when_ready();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.in_tready) begin
                @(negedge clk);
                break;
            end
        end
        bus.in_tvalid = 1'b0;
    endtask

    initial begin
        int c, np;
        rst_n = 1'b1;
        enable = 1'b0;
        is_bpsk = 1'b1;
        bus.in_tvalid = 1'b0;
        bus.in_tdata = 8'h00;

        vecs[0] = '{1'b1, 8'hA5, 8, 16'hCC33};
        vecs[1] = '{1'b0, 8'h1B, 4, 16'h1B00};
        vecs[2] = '{1'b1, 8'h00, 8, 16'h0000};
        vecs[3] = '{1'b1, 8'hFF, 8, 16'hFFFF};
        vecs[4] = '{1'b0, 8'hE4, 4, 16'hE400};
        vecs[5] = '{1'b1, 8'h3C, 8, 16'h0FF0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst I", bus.out_I_tdata, 32'd0);
        chk("rst Q", bus.out_Q_tdata, 32'd0);
        chk("rst tvalid", 32'(bus.out_tvalid), 32'd0);
        chk("rst mode", 32'(bus.out_is_bpsk), 32'd1);
        chk("rst underrun", 32'(underrun), 32'd0);
        chk("rst tready", 32'(bus.in_tready), 32'd0);

`ifndef PSK_DIFF_ENC_EN
        for (int i = 0; i < 6; i++) begin
            do_reset();
            is_bpsk = vecs[i].bpsk;
            send(vecs[i].data);
            enable = 1'b1;
            for (int s = 0; s < vecs[i].nsym; s++)
                check_sym($sformatf("vec%0d sym%0d", i, s),
                          vecs[i].signs[15-2*s], vecs[i].signs[14-2*s],
                          vecs[i].bpsk, s > 0);
            chk($sformatf("vec%0d underrun", i), 32'(underrun), 32'd0);
            enable = 1'b0;
        end

        // back-to-back bytes with in_tvalid held high
        do_reset();
        is_bpsk = 1'b1;
        send(8'h00);
        bus.in_tdata  = 8'hFF;
        bus.in_tvalid = 1'b1;
        enable = 1'b1;
        fork
            feed_when_ready();
            for (int s = 0; s < 16; s++)
                check_sym($sformatf("b2b sym%0d", s), s >= 8, s >= 8,
                          1'b1, s > 0);
        join
        chk("b2b underrun", 32'(underrun), 32'd0);

        // mode change mid-byte applies to the following byte
        do_reset();
        is_bpsk = 1'b0;
        send(8'h1B);
        bus.in_tdata  = 8'h80;
        bus.in_tvalid = 1'b1;
        enable = 1'b1;
        fork
            feed_when_ready();
            begin
                check_sym("tog q0", 1'b0, 1'b0, 1'b0, 1'b0);
                is_bpsk = 1'b1;
                check_sym("tog q1", 1'b0, 1'b1, 1'b0, 1'b1);
                check_sym("tog q2", 1'b1, 1'b0, 1'b0, 1'b1);
                check_sym("tog q3", 1'b1, 1'b1, 1'b0, 1'b1);
                check_sym("tog b0", 1'b1, 1'b1, 1'b1, 1'b1);
                for (int s = 1; s < 8; s++)
                    check_sym($sformatf("tog b%0d", s), 1'b0, 1'b0,
                              1'b1, 1'b1);
            end
        join
        enable = 1'b0;
`endif

        // underrun after a single QPSK byte
        do_reset();
        is_bpsk = 1'b0;
        send(8'h1B);
        enable = 1'b1;
        for (int s = 0; s < 4; s++)
            next_pulse(c);
        chk("ur pre", 32'(underrun), 32'd0);
        next_pulse(c);
        chk("ur pulse", 32'(c < 40), 32'd1);
        chk("ur gap", c, CPS);
        chk("ur I", bus.out_I_tdata, 32'd0);
        chk("ur Q", bus.out_Q_tdata, 32'd0);
        chk("ur flag", 32'(underrun), 32'd1);
        repeat (10) @(negedge clk);
        chk("ur sticky", 32'(underrun), 32'd1);
        do_reset();
        chk("ur cleared", 32'(underrun), 32'd0);

        // enable stall then async reset mid-byte
        is_bpsk = 1'b1;
        send(8'hA5);
        enable = 1'b1;
        check_sym("ar sym0", 1'b1, 1'b1, 1'b1, 1'b0);
        enable = 1'b0;
        np = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_tvalid) np++;
        end
        chk("stall pulses", np, 0);
        chk("stall hold I", bus.out_I_tdata, NA);
        enable = 1'b1;
        check_sym("ar sym1", 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("ar I", bus.out_I_tdata, 32'd0);
        chk("ar Q", bus.out_Q_tdata, 32'd0);
        chk("ar tvalid", 32'(bus.out_tvalid), 32'd0);
        chk("ar tready", 32'(bus.in_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar tready rel", 32'(bus.in_tready), 32'd1);
        send(8'h40);
        enable = 1'b1;
        check_sym("ar new0", 1'b0, 1'b0, 1'b1, 1'b0);
        check_sym("ar new1", 1'b1, 1'b1, 1'b1, 1'b1);
        enable = 1'b0;

        // bits 1,1,0 in BPSK
        do_reset();
        is_bpsk = 1'b1;
        send(8'hC0);
        enable = 1'b1;
`ifdef PSK_DIFF_ENC_EN
        check_sym("diff0", 1'b1, 1'b1, 1'b1, 1'b0);
        check_sym("diff1", 1'b0, 1'b0, 1'b1, 1'b1);
        check_sym("diff2", 1'b0, 1'b0, 1'b1, 1'b1);
`else
        check_sym("c0 sym0", 1'b1, 1'b1, 1'b1, 1'b0);
        check_sym("c0 sym1", 1'b1, 1'b1, 1'b1, 1'b1);
        check_sym("c0 sym2", 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
